// File: rtl/idma_obi_arbiter_pkg.sv
// idma_obi_arbiter_pkg: shared helper for index/pointer widths of the OBI arbiter
package idma_obi_arbiter_pkg;
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/idma_obi_arbiter_fifo.sv
// idma_obi_arbiter_fifo: in-order index FIFO recording which input owns each outstanding request
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
// pop_i/data_o read side (data_o is the head); full_o/empty_o derived from the registered count.
module idma_obi_arbiter_fifo
    import idma_obi_arbiter_pkg::*;
#(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
)(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q;
    assign full_o  = cnt_q == CntW'(Depth);
    assign empty_o = cnt_q == '0;
    assign data_o  = mem_q[rd_q];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
            if (pop_i) rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
            cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/idma_obi_arbiter.sv
// idma_obi_arbiter: round-robin arbiter sharing one OBI manager port among NumInp iDMA channels
// Ports: inp_a_* per-input A phase (req/addr/we/be/wdata in, gnt out); inp_r_* per-input R phase
// (valid out, ready in, rdata broadcast); oup_a_*/oup_r_* the shared OBI port; busy_o is high
// while a stalled request is locked or any granted request awaits its response.
module idma_obi_arbiter
    import idma_obi_arbiter_pkg::*;
#(
    parameter int unsigned NumInp         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned StrbWidth      = DataWidth / 8,
    parameter int unsigned IdxWidth       = idx_width(NumInp)
)(
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumInp-1:0]                   inp_a_req_i,
    input  logic [NumInp-1:0][AddrWidth-1:0]    inp_a_addr_i,
    input  logic [NumInp-1:0]                   inp_a_we_i,
    input  logic [NumInp-1:0][StrbWidth-1:0]    inp_a_be_i,
    input  logic [NumInp-1:0][DataWidth-1:0]    inp_a_wdata_i,
    output logic [NumInp-1:0]                   inp_a_gnt_o,
    output logic [NumInp-1:0]                   inp_r_valid_o,
    input  logic [NumInp-1:0]                   inp_r_ready_i,
    output logic [DataWidth-1:0]                inp_r_rdata_o,
    output logic                                oup_a_req_o,
    output logic [AddrWidth-1:0]                oup_a_addr_o,
    output logic                                oup_a_we_o,
    output logic [StrbWidth-1:0]                oup_a_be_o,
    output logic [DataWidth-1:0]                oup_a_wdata_o,
    input  logic                                oup_a_gnt_i,
    input  logic                                oup_r_valid_i,
    input  logic [DataWidth-1:0]                oup_r_rdata_i,
    output logic                                oup_r_ready_o
    ,output logic                               busy_o
);
    logic [IdxWidth-1:0] prio_q, sel_q, rr_idx, cand, winner, head;
    logic                lock_q, fifo_full, fifo_empty, win_req, push, pop, r_ok;
    // Last hit in a descending scan is the closest requester at or above prio_q.
    always_comb begin
        rr_idx = prio_q;
        cand   = '0;
        for (int i = NumInp - 1; i >= 0; i--) begin
            cand = IdxWidth'((int'(prio_q) + i) % NumInp);
            if (inp_a_req_i[cand]) rr_idx = cand;
        end
    end
    assign winner        = lock_q ? sel_q : rr_idx;
    assign win_req       = inp_a_req_i[winner];
    assign oup_a_req_o   = win_req & !fifo_full;
    assign oup_a_addr_o  = win_req ? inp_a_addr_i[winner] : '0;
    assign oup_a_we_o    = win_req & inp_a_we_i[winner];
    assign oup_a_be_o    = win_req ? inp_a_be_i[winner] : '0;
    assign oup_a_wdata_o = win_req ? inp_a_wdata_i[winner] : '0;
    assign push          = oup_a_req_o & oup_a_gnt_i;
    assign r_ok          = oup_r_valid_i & !fifo_empty;
    assign oup_r_ready_o = inp_r_ready_i[head] & !fifo_empty;
    assign pop           = oup_r_valid_i & oup_r_ready_o;
    assign inp_r_rdata_o = r_ok ? oup_r_rdata_i : '0;
    assign busy_o        = lock_q | !fifo_empty;
    always_comb begin
        inp_a_gnt_o           = '0;
        inp_a_gnt_o[winner]   = push;
        inp_r_valid_o         = '0;
        inp_r_valid_o[head]   = r_ok;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= '0;
            sel_q  <= '0;
            lock_q <= 1'b0;
        end else if (push) begin
            lock_q <= 1'b0;
            prio_q <= (winner == IdxWidth'(NumInp - 1)) ? '0 : winner + IdxWidth'(1);
        end else if (oup_a_req_o) begin
            lock_q <= 1'b1;
            sel_q  <= winner;
        end
    end
    idma_obi_arbiter_fifo #(
        .Width (IdxWidth),
        .Depth (MaxOutstanding)
    ) i_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
endmodule
